// File: rtl/bram_vector_writer.sv
`default_nettype none
// ============================================================================
//  Module   : bram_vector_writer
//  Brief    : Latches a packed vector of NUM_ELEMS W-bit elements and streams
//             it, one element per cycle, into consecutive BRAM addresses
//             starting at BASE_ADDR. All BRAM-facing outputs are registered.
//  Option   : `define BRAM_WRITER_VERIFY_EN adds a read-back pass after the
//             writes that compares every element and raises verify_err.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_vector_writer #(
  parameter int NUM_ELEMS  = 8,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 147480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_ELEMS*W-1:0]  data_in,
  output logic                    bram_en,
  output logic                    bram_wen,
  output logic                    bram_ren,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [W-1:0]            bram_din,
  input  logic [W-1:0]            bram_dout,
  output logic                    busy,
  output logic                    done,
  output logic                    verify_err
);

  // Counter is at least one bit wide so NUM_ELEMS=1 still elaborates.
  localparam int                     C_CNT_W      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int                     C_ELEM_SLOTS = 1 << C_CNT_W;
  localparam logic [ADDR_WIDTH-1:0]  C_BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [C_CNT_W-1:0]     C_LAST       = C_CNT_W'(NUM_ELEMS - 1);
  localparam logic [C_CNT_W-1:0]     C_ONE        = C_CNT_W'(1);

  // FINISH is the one-cycle hand-off between the last BRAM access and done.
`ifdef BRAM_WRITER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_FINISH = 3'd2,
    S_DONE   = 3'd3,
    S_VERIFY = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_FINISH = 3'd2,
    S_DONE   = 3'd3
  } state_t;
`endif

  state_t                   r_state, w_state;
  logic [C_CNT_W-1:0]       r_cnt, w_cnt, w_cnt_inc;
  logic [NUM_ELEMS*W-1:0]   r_shadow;
  logic                     w_shadow_load;
  logic                     r_en, w_en;
  logic                     r_wen, w_wen;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr;
  logic [W-1:0]             r_din, w_din;
  logic                     r_busy, w_busy;
  logic                     r_done, w_done;
  logic [W-1:0]             w_elem [C_ELEM_SLOTS];

  // Element view of the shadow vector, padded to a power of two so the
  // counter can index it directly without range issues.
  generate
    for (genvar gi = 0; gi < C_ELEM_SLOTS; gi++) begin : g_elem
      if (gi < NUM_ELEMS) begin : g_live
        assign w_elem[gi] = r_shadow[gi*W +: W];
      end else begin : g_pad
        assign w_elem[gi] = '0;
      end
    end
  endgenerate

  assign w_cnt_inc = r_cnt + C_ONE;

`ifdef BRAM_WRITER_VERIFY_EN
  logic                r_ren, w_ren;
  logic                w_verr_clr;
  logic                r_verr;
  logic                r_tag0_vld, r_tag1_vld;
  logic [C_CNT_W-1:0]  r_tag0_idx, r_tag1_idx;
  logic                w_mismatch;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state decode plus next values of every registered BRAM output.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_shadow_load = 1'b0;
    w_en          = 1'b0;
    w_wen         = 1'b0;
    w_addr        = r_addr;
    w_din         = r_din;
    w_busy        = r_busy;
    w_done        = r_done;
`ifdef BRAM_WRITER_VERIFY_EN
    w_ren         = 1'b0;
    w_verr_clr    = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Element 0 goes out straight from data_in because the shadow
          // register is loaded on this same edge.
          w_state       = S_WRITE;
          w_cnt         = '0;
          w_shadow_load = 1'b1;
          w_en          = 1'b1;
          w_wen         = 1'b1;
          w_addr        = C_BASE;
          w_din         = data_in[W-1:0];
          w_busy        = 1'b1;
          w_done        = 1'b0;
`ifdef BRAM_WRITER_VERIFY_EN
          w_verr_clr    = 1'b1;
`endif
        end
      end
      S_WRITE: begin
        if (r_cnt == C_LAST) begin
`ifdef BRAM_WRITER_VERIFY_EN
          w_state = S_VERIFY;
          w_cnt   = '0;
          w_en    = 1'b1;
          w_ren   = 1'b1;
          w_addr  = C_BASE;
`else
          w_state = S_FINISH;
`endif
        end else begin
          w_cnt  = w_cnt_inc;
          w_en   = 1'b1;
          w_wen  = 1'b1;
          w_addr = r_addr + ADDR_WIDTH'(1);
          w_din  = w_elem[w_cnt_inc];
        end
      end
`ifdef BRAM_WRITER_VERIFY_EN
      S_VERIFY: begin
        if (r_cnt == C_LAST) begin
          w_state = S_DRAIN;
          w_cnt   = '0;
        end else begin
          w_cnt  = w_cnt_inc;
          w_en   = 1'b1;
          w_ren  = 1'b1;
          w_addr = r_addr + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles let the final read return and be compared.
        if (r_cnt == C_ONE) begin
          w_state = S_FINISH;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
`endif
      S_FINISH: begin
        w_state = S_DONE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_en     <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= C_BASE;
      r_din    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt;
      r_en   <= w_en;
      r_wen  <= w_wen;
      r_addr <= w_addr;
      r_din  <= w_din;
      r_busy <= w_busy;
      r_done <= w_done;
      if (w_shadow_load) begin
        r_shadow <= data_in;
      end
    end
  end

  assign bram_en   = r_en;
  assign bram_wen  = r_wen;
  assign bram_addr = r_addr;
  assign bram_din  = r_din;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef BRAM_WRITER_VERIFY_EN
  // Read data for the element presented in cycle c is sampled two stages
  // later, so the tag rides a two-deep pipeline alongside it.
  assign w_mismatch = r_tag1_vld && (bram_dout != w_elem[r_tag1_idx]);

  // Read-enable register, tag pipeline and sticky mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ren      <= 1'b0;
      r_tag0_vld <= 1'b0;
      r_tag0_idx <= '0;
      r_tag1_vld <= 1'b0;
      r_tag1_idx <= '0;
      r_verr     <= 1'b0;
    end else begin
      r_ren      <= w_ren;
      r_tag0_vld <= r_ren;
      r_tag0_idx <= r_cnt;
      r_tag1_vld <= r_tag0_vld;
      r_tag1_idx <= r_tag0_idx;
      if (w_verr_clr) begin
        r_verr <= 1'b0;
      end else if (w_mismatch) begin
        r_verr <= 1'b1;
      end
    end
  end

  assign bram_ren   = r_ren;
  assign verify_err = r_verr;
`else
  assign bram_ren   = 1'b0;
  assign verify_err = 1'b0;

  // Read data has no consumer without the verify pass.
  logic w_unused_dout;
  assign w_unused_dout = ^bram_dout;
`endif

endmodule
`default_nettype wire
